// File: rtl/mem_mover_pkg.sv
// Shared definitions for the mem_mover block: FSM states, op encodings, word stride.
package mem_mover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FILL,
    ST_FIN
  } state_t;

  localparam logic OP_COPY     = 1'b0;
  localparam logic OP_FILL     = 1'b1;
  localparam int   WORD_STRIDE = 2;

endpackage

// File: rtl/mover_addr_gen.sv
// Source/destination pointers, step direction and remaining-word count for mem_mover.
module mover_addr_gen
  import mem_mover_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_bwd,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [15:0]       i_count,
  input  logic              i_step_src,
  input  logic              i_step_dst,
  output logic [ADDR_W-1:0] o_src,
  output logic [ADDR_W-1:0] o_dst,
  output logic [15:0]       o_rem
);

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [15:0]       r_rem;
  logic              r_bwd;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_stride;

  // Backward transfers begin at the last word of each region.
  always_comb begin
    w_stride = ADDR_W'(WORD_STRIDE);
    w_span   = i_bwd ? ADDR_W'({i_count - 16'd1, 1'b0}) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
      r_bwd <= 1'b0;
    end else if (i_load) begin
      r_src <= (i_src & ~ADDR_W'(1)) + w_span;
      r_dst <= (i_dst & ~ADDR_W'(1)) + w_span;
      r_rem <= i_count;
      r_bwd <= i_bwd;
    end else begin
      if (i_step_src) begin
        r_src <= r_bwd ? r_src - w_stride : r_src + w_stride;
      end
      if (i_step_dst) begin
        r_dst <= r_bwd ? r_dst - w_stride : r_dst + w_stride;
        r_rem <= r_rem - 16'd1;
      end
    end
  end

  assign o_src = r_src;
  assign o_dst = r_dst;
  assign o_rem = r_rem;

endmodule

// File: rtl/mem_mover.sv
// Word copy/fill engine driving a single-port memory; COPY is 2 cycles/word, FILL 1, plus a done cycle.
// Optional macro MOVER_OVERLAP_EN runs overlapping dst>src copies backward.
module mem_mover
  import mem_mover_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [15:0]       count,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] WData,
  input  logic [DATA_W-1:0] RData,
  output logic              MemRead,
  output logic              MemWrite
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_fill;
  logic              w_load;
  logic              w_step_src;
  logic              w_step_dst;
  logic              w_bwd;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;
  logic [15:0]       w_rem;

`ifdef MOVER_OVERLAP_EN
  logic [ADDR_W:0] w_src_ext;
  logic [ADDR_W:0] w_dst_ext;
  logic [ADDR_W:0] w_src_end;

  // Copy backward only when dst lands inside the not-yet-read source window.
  always_comb begin
    w_src_ext = {1'b0, src & ~ADDR_W'(1)};
    w_dst_ext = {1'b0, dst & ~ADDR_W'(1)};
    w_src_end = w_src_ext + (ADDR_W+1)'({count, 1'b0});
    w_bwd     = (op == OP_COPY) && (w_dst_ext > w_src_ext) && (w_dst_ext < w_src_end);
  end
`else
  assign w_bwd = 1'b0;
`endif

  mover_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_clk      (Clk),
    .i_rst_n    (Rst_n),
    .i_load     (w_load),
    .i_bwd      (w_bwd),
    .i_src      (src),
    .i_dst      (dst),
    .i_count    (count),
    .i_step_src (w_step_src),
    .i_step_dst (w_step_dst),
    .o_src      (w_src),
    .o_dst      (w_dst),
    .o_rem      (w_rem)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_fill <= fill_val;
      end
      if (r_state == ST_RD) begin
        r_hold <= RData;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemAddr    = '0;
    WData      = '0;
    w_load     = 1'b0;
    w_step_src = 1'b0;
    w_step_dst = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          if (count == 16'd0)     w_next = ST_FIN;
          else if (op == OP_FILL) w_next = ST_FILL;
          else                    w_next = ST_RD;
        end
      end
      ST_RD: begin
        MemRead    = 1'b1;
        MemAddr    = w_src;
        w_step_src = 1'b1;
        w_next     = ST_WR;
      end
      ST_WR: begin
        MemWrite   = 1'b1;
        MemAddr    = w_dst;
        WData      = r_hold;
        w_step_dst = 1'b1;
        w_next     = (w_rem == 16'd1) ? ST_FIN : ST_RD;
      end
      ST_FILL: begin
        MemWrite   = 1'b1;
        MemAddr    = w_dst;
        WData      = r_fill;
        w_step_dst = 1'b1;
        w_next     = (w_rem == 16'd1) ? ST_FIN : ST_FILL;
      end
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_mover.sv
// Bench for mem_mover: per-cycle compare against a transaction-level model plus directed literal checks.
module tb_mem_mover;
  import mem_mover_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] src = '0, dst = '0, count = '0, fill_val = '0;
  logic        busy, done, MemRead, MemWrite;
  logic [15:0] MemAddr, WData, RData;

  logic [15:0] mem  [0:32767];
  logic [15:0] mmem [0:32767];

  typedef struct packed {
    logic        bsy;
    logic        dn;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } rec_t;

  rec_t        expq[$];
  logic [15:0] wr_log[$];
  int          tests = 0, fails = 0, cyc = 0, done_at = -1, nrd = 0;

  mem_mover dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .op(op), .src(src), .dst(dst),
    .count(count), .fill_val(fill_val), .busy(busy), .done(done),
    .MemAddr(MemAddr), .WData(WData), .RData(RData),
    .MemRead(MemRead), .MemWrite(MemWrite)
  );

  always #5 Clk = ~Clk;

  assign RData = MemRead ? mem[MemAddr[15:1]] : 16'h0000;

  // Writes land mid-cycle; no read shares a cycle with a write, so this matches an edge commit.
  always @(negedge Clk) if (MemWrite) mem[MemAddr[15:1]] = WData;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  always @(negedge Clk) begin
    rec_t e;
    rec_t a;
    e = (expq.size() > 0) ? expq.pop_front() : '0;
    a = {busy, done, MemRead, MemWrite, MemAddr, WData};
    chk("cycle", 64'(a), 64'(e));
    if (e.wr) mmem[e.addr[15:1]] = e.data;
    cyc++;
    if (done) done_at = cyc;
    if (MemWrite) wr_log.push_back(MemAddr);
    if (MemRead) nrd++;
  end

  task automatic build(input logic o, input logic [15:0] s_in, input logic [15:0] d_in,
                       input logic [15:0] n, input logic [15:0] f);
    logic [15:0] s, d, sa, da, v;
    logic [15:0] ov [logic [15:0]];
    bit bwd;
    int k;
    s = s_in & 16'hFFFE;
    d = d_in & 16'hFFFE;
    if (n != 16'd0) begin
      if (o == OP_FILL) begin
        for (int i = 0; i < int'(n); i++)
          expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, d + 16'(2 * i), f});
      end else begin
        bwd = 1'b0;
`ifdef MOVER_OVERLAP_EN
        bwd = (d > s) && ({1'b0, d} < ({1'b0, s} + {n, 1'b0}));
`endif
        for (int i = 0; i < int'(n); i++) begin
          k  = bwd ? int'(n) - 1 - i : i;
          sa = s + 16'(2 * k);
          da = d + 16'(2 * k);
          v  = ov.exists(sa) ? ov[sa] : mmem[sa[15:1]];
          expq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, sa, 16'h0000});
          expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, da, v});
          ov[da] = v;
        end
      end
    end
    expq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000});
  endtask

  task automatic do_cmd(input logic o, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] n, input logic [15:0] f);
    @(posedge Clk);
    #1;
    start = 1'b1; op = o; src = s; dst = d; count = n; fill_val = f;
    @(posedge Clk);
    #1;
    start = 1'b0;
    wr_log.delete();
    done_at = -1;
    nrd = 0;
    cyc = 0;
    build(o, s, d, n, f);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && expq.size() > 0; i++) @(negedge Clk);
    chk("timeout", 64'(expq.size()), 64'd0);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a[15:1]]  = v;
    mmem[a[15:1]] = v;
  endtask

  task automatic mem_cmp(input string nm);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] !== mmem[i]) diffs++;
    chk(nm, 64'(diffs), 64'd0);
  endtask

  initial begin
    logic [15:0] s, d, n;
    for (int i = 0; i < 32768; i++) begin
      mem[i]  = 16'h0000;
      mmem[i] = 16'h0000;
    end
    #12;
    chk("reset_state", 64'({busy, done, MemRead, MemWrite, MemAddr, WData}), 64'd0);
    #5 Rst_n = 1'b1;

    poke(16'h0100, 16'hAAAA); poke(16'h0102, 16'hBBBB); poke(16'h0104, 16'hCCCC);
    do_cmd(OP_COPY, 16'h0100, 16'h0200, 16'd3, 16'h0000);
    wait_idle();
    chk("copy3_w0", 64'(mem[16'h0200 >> 1]), 64'hAAAA);
    chk("copy3_w1", 64'(mem[16'h0202 >> 1]), 64'hBBBB);
    chk("copy3_w2", 64'(mem[16'h0204 >> 1]), 64'hCCCC);
    chk("copy3_done_cycle", 64'(done_at), 64'd7);

    do_cmd(OP_FILL, 16'h0000, 16'h0300, 16'd4, 16'h1234);
    wait_idle();
    chk("fill4_nwr", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      chk("fill4_addr", 64'(wr_log[i]), 64'(16'h0300 + 16'(2 * i)));
    chk("fill4_data", 64'(mem[16'h0306 >> 1]), 64'h1234);
    chk("fill4_done_cycle", 64'(done_at), 64'd5);

    do_cmd(OP_COPY, 16'h0100, 16'h0400, 16'd0, 16'h0000);
    wait_idle();
    chk("cnt0_reads", 64'(nrd), 64'd0);
    chk("cnt0_writes", 64'(wr_log.size()), 64'd0);
    chk("cnt0_done_cycle", 64'(done_at), 64'd1);

    poke(16'h0100, 16'd1); poke(16'h0102, 16'd2); poke(16'h0104, 16'd3); poke(16'h0106, 16'd0);
    do_cmd(OP_COPY, 16'h0100, 16'h0102, 16'd3, 16'h0000);
    wait_idle();
`ifdef MOVER_OVERLAP_EN
    chk("ovl_w0", 64'(mem[16'h0102 >> 1]), 64'd1);
    chk("ovl_w1", 64'(mem[16'h0104 >> 1]), 64'd2);
    chk("ovl_w2", 64'(mem[16'h0106 >> 1]), 64'd3);
`else
    chk("ovl_w0", 64'(mem[16'h0102 >> 1]), 64'd1);
    chk("ovl_w1", 64'(mem[16'h0104 >> 1]), 64'd1);
    chk("ovl_w2", 64'(mem[16'h0106 >> 1]), 64'd1);
`endif

    do_cmd(OP_FILL, 16'h0000, 16'hFFFE, 16'd2, 16'h5A5A);
    wait_idle();
    chk("wrap_nwr", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      chk("wrap_a0", 64'(wr_log[0]), 64'hFFFE);
      chk("wrap_a1", 64'(wr_log[1]), 64'h0000);
    end
    mem_cmp("mem_directed");

    // Reset after the second of five words, with a stray start mid-transfer.
    for (int i = 0; i < 5; i++) poke(16'h0400 + 16'(2 * i), 16'h11 * 16'(i + 1));
    for (int i = 0; i < 5; i++) poke(16'h0500 + 16'(2 * i), 16'hDEAD);
    do_cmd(OP_COPY, 16'h0400, 16'h0500, 16'd5, 16'h0000);
    @(posedge Clk);
    #1;
    start = 1'b1; op = OP_FILL; dst = 16'h0600; count = 16'd2; fill_val = 16'hBEEF;
    @(posedge Clk);
    #1;
    start = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("pre_rst_rd", 64'(MemRead), 64'd1);
    #1;
    Rst_n = 1'b0;
    expq.delete();
    #1;
    chk("rst_async", 64'({busy, done, MemRead, MemWrite, MemAddr, WData}), 64'd0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    #1;
    chk("rst_no_done", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_kept_w0", 64'(mem[16'h0500 >> 1]), 64'h0011);
    chk("rst_kept_w1", 64'(mem[16'h0502 >> 1]), 64'h0022);
    chk("rst_unwritten", 64'(mem[16'h0504 >> 1]), 64'hDEAD);
    mem_cmp("mem_after_reset");

    for (int i = 0; i < 64; i++) poke(16'h1000 + 16'(2 * i), 16'($urandom));
    for (int t = 0; t < 24; t++) begin
      s = 16'h1000 + 16'(2 * $urandom_range(0, 31)) + 16'($urandom_range(0, 1));
      d = 16'h1000 + 16'(2 * $urandom_range(0, 31)) + 16'($urandom_range(0, 1));
      n = 16'($urandom_range(0, 6));
      do_cmd(1'($urandom_range(0, 1)), s, d, n, 16'($urandom));
      wait_idle();
    end
    mem_cmp("mem_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
